// File: rtl/rsn_release_sequencer.sv
// Release sequencer for negative-edge set/reset flop banks: synchronises set/reset
// requests and drives mutually exclusive, minimum-width RN/SETN strobes with guard gaps.
module rsn_release_sequencer #(
    parameter int SYNC_STAGES  = 2,
    parameter int HOLD_CYCLES  = 4,
    parameter int GUARD_CYCLES = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic RST_REQ,
    input  logic SET_REQ,
    output logic RN,
    output logic SETN,
    output logic BUSY,
    output logic DONE
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD_R = 3'd1,
        HOLD_S = 3'd2,
        PRE_R  = 3'd3,
        GUARD  = 3'd4
    } state_t;

    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GUARD_LOAD = (GUARD_CYCLES > 0) ? 8'(GUARD_CYCLES - 1) : 8'd0;
    // With no guard time a finished strobe releases straight back to IDLE.
    localparam state_t     EXIT_STATE = (GUARD_CYCLES > 0) ? GUARD : IDLE;

    logic [SYNC_STAGES-1:0] rst_chain_r;
    logic [SYNC_STAGES-1:0] set_chain_r;
    logic                   rst_sync_s;
    logic                   set_sync_s;
    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [7:0]             cnt_r;
    logic [7:0]             cnt_nxt_s;
    logic                   rn_r;
    logic                   setn_r;
    logic                   busy_r;
    logic                   done_r;

    // Output decode {RN, SETN, BUSY}; unknown encodings fall back to the reset strobe.
    function automatic logic [2:0] decode_outputs(input state_t s);
        logic [2:0] d;
        case (s)
            IDLE:    d = 3'b110;
            HOLD_R:  d = 3'b011;
            HOLD_S:  d = 3'b101;
            PRE_R:   d = 3'b111;
            GUARD:   d = 3'b111;
            default: d = 3'b011;
        endcase
        return d;
    endfunction

    assign rst_sync_s = rst_chain_r[SYNC_STAGES-1];
    assign set_sync_s = set_chain_r[SYNC_STAGES-1];

    // Request synchroniser chains.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rst_chain_r <= '0;
            set_chain_r <= '0;
        end else begin
            rst_chain_r <= {rst_chain_r[SYNC_STAGES-2:0], RST_REQ};
            set_chain_r <= {set_chain_r[SYNC_STAGES-2:0], SET_REQ};
        end
    end

    // Next-state and hold/guard counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (rst_sync_s) begin
                    state_nxt_s = HOLD_R;
                    cnt_nxt_s   = HOLD_LOAD;
                end else if (set_sync_s) begin
                    state_nxt_s = HOLD_S;
                    cnt_nxt_s   = HOLD_LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            HOLD_R: begin
                if (cnt_r != 8'd0) begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end else if (!rst_sync_s) begin
                    state_nxt_s = EXIT_STATE;
                    cnt_nxt_s   = GUARD_LOAD;
                end else begin
                    state_nxt_s = HOLD_R;
                end
            end
            HOLD_S: begin
                // A reset request aborts the set via a both-high cycle in PRE_R.
                if (rst_sync_s) begin
                    state_nxt_s = PRE_R;
                    cnt_nxt_s   = 8'd0;
                end else if (cnt_r != 8'd0) begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end else if (!set_sync_s) begin
                    state_nxt_s = EXIT_STATE;
                    cnt_nxt_s   = GUARD_LOAD;
                end else begin
                    state_nxt_s = HOLD_S;
                end
            end
            PRE_R: begin
                state_nxt_s = HOLD_R;
                cnt_nxt_s   = HOLD_LOAD;
            end
            GUARD: begin
                if (rst_sync_s) begin
                    state_nxt_s = HOLD_R;
                    cnt_nxt_s   = HOLD_LOAD;
                end else if (cnt_r != 8'd0) begin
                    cnt_nxt_s = cnt_r - 8'd1;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 8'd0;
                end
            end
            default: begin
                state_nxt_s = HOLD_R;
                cnt_nxt_s   = HOLD_LOAD;
            end
        endcase
    end

    // State register with outputs registered from the next-state decode.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= HOLD_R;
            cnt_r   <= HOLD_LOAD;
            rn_r    <= 1'b0;
            setn_r  <= 1'b1;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r                  <= state_nxt_s;
            cnt_r                    <= cnt_nxt_s;
            {rn_r, setn_r, busy_r}   <= decode_outputs(state_nxt_s);
            done_r                   <= (state_nxt_s == IDLE) && (state_r != IDLE);
        end
    end

    assign RN   = rn_r;
    assign SETN = setn_r;
    assign BUSY = busy_r;
    assign DONE = done_r;

endmodule

// File: tb/tb_rsn_release_sequencer.sv
// Scoreboard bench: directed scenarios on a default instance, random stress on a
// HOLD_CYCLES=1 / GUARD_CYCLES=0 instance.
module tb_rsn_release_sequencer;

    logic CLK = 1'b0;
    logic RST;
    logic RST_REQ, SET_REQ, RN, SETN, BUSY, DONE;
    logic rst_req_b, set_req_b, rn_b, setn_b, busy_b, done_b;

    always #5 CLK = ~CLK;

    rsn_release_sequencer dut (
        .CLK(CLK), .RST(RST), .RST_REQ(RST_REQ), .SET_REQ(SET_REQ),
        .RN(RN), .SETN(SETN), .BUSY(BUSY), .DONE(DONE)
    );

    rsn_release_sequencer #(.SYNC_STAGES(2), .HOLD_CYCLES(1), .GUARD_CYCLES(0)) dut_b (
        .CLK(CLK), .RST(RST), .RST_REQ(rst_req_b), .SET_REQ(set_req_b),
        .RN(rn_b), .SETN(setn_b), .BUSY(busy_b), .DONE(done_b)
    );

    typedef struct {
        string name;
        int    npulse;
        bit    is_set;
        int    width;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   tests = 0;
    int   fails = 0;
    bit   mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((BUSY !== 1'b0 || sb.size() != 0) && n < 60) begin
            step(1);
            n++;
        end
        check("idle_timeout", n >= 60, 0);
        if (n >= 60) sb.delete();
        step(3);
    endtask

    // Monitor for the default instance: pulse tracking, invariants, scoreboard pops on DONE.
    logic prev_rn = 1'b1, prev_setn = 1'b1;
    int   rn_w = 0, setn_w = 0, npulse = 0, last_w = 0;
    bit   last_set = 1'b0;

    always @(negedge CLK) begin
        if (mon_en) begin
            check("overlap", (!RN && !SETN), 0);
            check("same_edge_toggle", (RN !== prev_rn) && (SETN !== prev_setn), 0);
            if (!RN) rn_w++;
            else if (!prev_rn) begin
                npulse++; last_set = 1'b0; last_w = rn_w; rn_w = 0;
            end
            if (!SETN) setn_w++;
            else if (!prev_setn) begin
                npulse++; last_set = 1'b1; last_w = setn_w; setn_w = 0;
            end
            if (DONE) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    cur = sb.pop_front();
                    check({cur.name, "_pulses"}, npulse, cur.npulse);
                    check({cur.name, "_kind"}, {31'd0, last_set}, {31'd0, cur.is_set});
                    check({cur.name, "_width"}, last_w, cur.width);
                end
                check("busy_at_done", BUSY, 0);
                npulse = 0;
            end
            prev_rn   = RN;
            prev_setn = SETN;
        end
    end

    // Monitor for the stress instance: invariants and a strobe before every DONE.
    logic prev_rn_b = 1'b1, prev_setn_b = 1'b1;
    int   pulses_b = 0;

    always @(negedge CLK) begin
        if (mon_en) begin
            check("b_overlap", (!rn_b && !setn_b), 0);
            check("b_same_edge_toggle", (rn_b !== prev_rn_b) && (setn_b !== prev_setn_b), 0);
            if ((rn_b && !prev_rn_b) || (setn_b && !prev_setn_b)) pulses_b++;
            if (done_b) begin
                check("b_done_after_pulse", pulses_b > 0, 1);
                check("b_busy_at_done", busy_b, 0);
                pulses_b = 0;
            end
            prev_rn_b   = rn_b;
            prev_setn_b = setn_b;
        end
    end

    initial begin
        RST = 1'b1; RST_REQ = 1'b0; SET_REQ = 1'b0;
        rst_req_b = 1'b0; set_req_b = 1'b0;

        // Block reset: 3 RST edges, then 4 hold cycles -> RN low for 6 sampled cycles.
        sb.push_back('{"reset", 1, 1'b0, 6});
        step(1);
        mon_en = 1'b1;
        check("rst_rn", RN, 0);
        check("rst_setn", SETN, 1);
        check("rst_busy", BUSY, 1);
        check("rst_done", DONE, 0);
        step(2);
        RST = 1'b0;
        wait_idle();
        check("idle_rn", RN, 1);
        check("idle_setn", SETN, 1);

        // 10-cycle set request: SETN falls 3 edges later, low for 10 cycles.
        sb.push_back('{"set10", 1, 1'b1, 10});
        SET_REQ = 1'b1;
        step(2);
        check("set10_lat_pre", SETN, 1);
        step(1);
        check("set10_lat", SETN, 0);
        check("set10_rn", RN, 1);
        step(7);
        SET_REQ = 1'b0;
        wait_idle();

        // Single-cycle set request still gives a full 4-cycle SETN pulse.
        sb.push_back('{"set1", 1, 1'b1, 4});
        SET_REQ = 1'b1;
        step(1);
        SET_REQ = 1'b0;
        step(2);
        check("set1_setn", SETN, 0);
        check("set1_busy", BUSY, 1);
        wait_idle();

        // Reset request during HOLD_S: SETN 4 cycles, one both-high cycle, RN 4 cycles.
        sb.push_back('{"abort", 2, 1'b0, 4});
        SET_REQ = 1'b1;
        step(4);
        check("abort_setn_low", SETN, 0);
        RST_REQ = 1'b1;
        step(3);
        check("abort_pre_rn", RN, 1);
        check("abort_pre_setn", SETN, 1);
        step(1);
        check("abort_rn_low", RN, 0);
        check("abort_setn_high", SETN, 1);
        RST_REQ = 1'b0;
        SET_REQ = 1'b0;
        wait_idle();

        // Simultaneous requests: reset wins, pending set follows after guard and IDLE.
        sb.push_back('{"both_r", 1, 1'b0, 4});
        sb.push_back('{"both_s", 1, 1'b1, 4});
        RST_REQ = 1'b1;
        SET_REQ = 1'b1;
        step(1);
        RST_REQ = 1'b0;
        step(2);
        check("both_rn", RN, 0);
        check("both_setn", SETN, 1);
        step(6);
        check("both_later_setn", SETN, 0);
        check("both_later_rn", RN, 1);
        SET_REQ = 1'b0;
        wait_idle();

        // Random stress on the minimal-timing instance.
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 9) == 0) rst_req_b = ~rst_req_b;
            if ($urandom_range(0, 5) == 0) set_req_b = ~set_req_b;
            step(1);
        end
        rst_req_b = 1'b0;
        set_req_b = 1'b0;
        step(10);
        check("b_final_busy", busy_b, 0);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
